bcd_to_binary_seq: RTL



---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_to_binary_seq_nibble_correct.sv | 11 +
 rtl/bcd_to_binary_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

    localparam int DEF_NUM_DIGITS = 3;
    localparam int DEF_OUT_W      = 8;
    localparam int BCD_W          = 4 * DEF_NUM_DIGITS;
    localparam int CNT_W          = $clog2(DEF_OUT_W);

    localparam logic [3:0] DIGIT_MAX   = 4'd9;
    localparam logic [3:0] CORR_THRESH = 4'd8;
    localparam logic [3:0] CORR_SUB    = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_to_binary_seq_nibble_correct.sv
// Reverse double-dabble digit correction: a nibble of 8 or more loses 3.
module bcd_nibble_correct
    import bcd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= CORR_THRESH) ? (i_nib - CORR_SUB) : i_nib;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: shift right, correct digits, OUT_W iterations.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int OUT_W      = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        bin_out,
    output logic                    err_digit,
    output logic                    err_ovf,
    output logic                    busy,
    output state_t                  dbg_state
);

    localparam int L_BCD_W  = 4 * NUM_DIGITS;
    localparam int L_WORK_W = L_BCD_W + OUT_W;
    localparam int L_CNT_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [L_CNT_W-1:0] LAST_ITER = L_CNT_W'(OUT_W - 1);

    state_t                r_state;
    logic [L_WORK_W-1:0]   r_work;
    logic [L_CNT_W-1:0]    r_cnt;
    logic                  r_err_pend;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [OUT_W-1:0]      r_bin;
    logic                  r_err_digit;
    logic                  r_err_ovf;

    logic [L_WORK_W-1:0]   w_shift;
    logic [L_WORK_W-1:0]   w_next;
    logic                  w_bad_digit;
    logic                  w_ovf;

    assign w_shift = r_work >> 1;
    assign w_next[OUT_W-1:0] = w_shift[OUT_W-1:0];

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_corr
            bcd_nibble_correct u_corr (
                .i_nib (w_shift[OUT_W+4*g +: 4]),
                .o_nib (w_next[OUT_W+4*g +: 4])
            );
        end
    endgenerate

    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > DIGIT_MAX) w_bad_digit = 1'b1;
        end
    end

    // Anything left in the BCD field after the last shift means value > 2^OUT_W-1.
    assign w_ovf = |w_next[L_WORK_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_err_pend  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_bin       <= '0;
            r_err_digit <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work     <= {bcd_in, {OUT_W{1'b0}}};
                        r_err_pend <= w_bad_digit;
                        r_cnt      <= '0;
                        r_state    <= CONV;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                CONV: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_err_digit <= r_err_pend;
                        r_err_ovf   <= w_ovf && !r_err_pend;
                        r_bin       <= (r_err_pend || w_ovf) ? '0 : w_next[OUT_W-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign bin_out   = r_bin;
    assign err_digit = r_err_digit;
    assign err_ovf   = r_err_ovf;
    assign dbg_state = r_state;

endmodule
